// File: rtl/array_mem_responder.sv
// DEPTH-word array shared by a host port and a kernel port, with 1-cycle registered reads,
// a clear sequencer and an ownership handoff. Define ARRAY_MEM_WRITE_FORWARD_EN for write-first reads.
module array_mem_responder #(
  parameter int DATA_W   = 1,
  parameter int ADDR_W   = 1,
  parameter int DEPTH    = 2,
  parameter int INIT_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              controlArr,
  input  logic              arrWEnable,
  input  logic [ADDR_W-1:0] arrAddr,
  input  logic [DATA_W-1:0] arrWData,
  output logic [DATA_W-1:0] arrRData,
  input  logic              hostWEnable,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWData,
  output logic [DATA_W-1:0] hostRData,
  input  logic              clearStart,
  output logic              busy,
  output logic              oobErr
);
  typedef enum logic [1:0] {IDLE, CLEAR, HANDOFF} state_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] INIT_W = DATA_W'(INIT_VAL);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_nxt;
  logic              owner, owner_nxt;  // 1 = kernel
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  req_t              req;
  logic              oob, serve, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, rd_word;

  assign req  = owner ? '{arrWEnable, arrAddr, arrWData} : '{hostWEnable, hostAddr, hostWData};
  assign busy = (state != IDLE);

  // A fully populated address space can never be out of range.
  generate
    if (DEPTH < (2 ** ADDR_W)) begin : g_oob
      assign oob = ({1'b0, req.addr} >= (ADDR_W + 1)'(DEPTH));
    end else begin : g_no_oob
      assign oob = 1'b0;
    end
  endgenerate

`ifdef ARRAY_MEM_WRITE_FORWARD_EN
  assign rd_word = oob ? '0 : (req.we ? req.wdata : mem[req.addr]);
`else
  assign rd_word = oob ? '0 : mem[req.addr];
`endif

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    clr_addr_nxt = clr_addr;
    serve        = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = req.addr;
    mem_wdata    = req.wdata;
    unique case (state)
      IDLE: begin
        serve  = 1'b1;
        mem_we = req.we && !oob;
        // Clear wins; a pending owner change is picked up once CLEAR returns here.
        if (clearStart) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end else if (controlArr != owner) begin
          state_nxt = HANDOFF;
        end
      end
      CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_addr;
        mem_wdata    = INIT_W;
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST) state_nxt = IDLE;
      end
      HANDOFF: begin
        owner_nxt = ~owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      clr_addr  <= '0;
      arrRData  <= '0;
      hostRData <= '0;
      oobErr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      clr_addr <= clr_addr_nxt;
      if (serve) begin
        if (owner) arrRData  <= rd_word;
        else       hostRData <= rd_word;
        if (oob) oobErr <= 1'b1;
      end
    end
  end

  // Contents are not reset; a reset mid-clear simply stops further writes.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end
endmodule

// File: tb/tb_array_mem_responder.sv
// Bench for array_mem_responder: directed table, handoff/clear/reset/out-of-range sequences,
// and randomized owner traffic against an array model.
module tb_array_mem_responder;
`ifdef ARRAY_MEM_WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       controlArr = 1'b0, clearStart = 1'b0;
  logic       arrWEnable = 1'b0, hostWEnable = 1'b0;
  logic [1:0] arrAddr = '0, hostAddr = '0;
  logic [3:0] arrWData = '0, hostWData = '0;
  logic [3:0] arrRData, hostRData;
  logic       busy, oobErr;

  logic       b_rst = 1'b1;
  logic       b_controlArr = 1'b0, b_clearStart = 1'b0;
  logic       b_arrWEnable = 1'b0, b_hostWEnable = 1'b0;
  logic [1:0] b_arrAddr = '0, b_hostAddr = '0;
  logic [3:0] b_arrWData = '0, b_hostWData = '0;
  logic [3:0] b_arrRData, b_hostRData;
  logic       b_busy, b_oobErr;

  always #5 clk = ~clk;

  array_mem_responder #(.DATA_W(4), .ADDR_W(2), .DEPTH(4), .INIT_VAL(3)) u_dut (
    .clk(clk), .rst(rst), .controlArr(controlArr),
    .arrWEnable(arrWEnable), .arrAddr(arrAddr), .arrWData(arrWData), .arrRData(arrRData),
    .hostWEnable(hostWEnable), .hostAddr(hostAddr), .hostWData(hostWData), .hostRData(hostRData),
    .clearStart(clearStart), .busy(busy), .oobErr(oobErr));

  array_mem_responder #(.DATA_W(4), .ADDR_W(2), .DEPTH(3), .INIT_VAL(3)) u_dut3 (
    .clk(clk), .rst(b_rst), .controlArr(b_controlArr),
    .arrWEnable(b_arrWEnable), .arrAddr(b_arrAddr), .arrWData(b_arrWData), .arrRData(b_arrRData),
    .hostWEnable(b_hostWEnable), .hostAddr(b_hostAddr), .hostWData(b_hostWData),
    .hostRData(b_hostRData), .clearStart(b_clearStart), .busy(b_busy), .oobErr(b_oobErr));

  int n_pass = 0, n_chk = 0;
  logic [3:0] mdl [4];
  logic [3:0] exp_h, exp_k;

  typedef struct {
    logic       we;
    logic [1:0] a;
    logic [3:0] d;
    logic [3:0] eh;
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Behavioural array: one access by the owner, returns what its RData should show next.
  function automatic logic [3:0] srv(input logic we, input logic [1:0] a, input logic [3:0] d);
    logic [3:0] r;
    r = (FWD && we) ? d : mdl[a];
    if (we) mdl[a] = d;
    return r;
  endfunction

  initial begin
    logic kern;
    int   cnt;
    tbl[0] = '{1'b1, 2'd1, 4'd5, FWD ? 4'd5 : 4'd3};
    tbl[1] = '{1'b0, 2'd1, 4'd0, 4'd5};
    tbl[2] = '{1'b1, 2'd2, 4'd6, FWD ? 4'd6 : 4'd3};
    tbl[3] = '{1'b0, 2'd2, 4'd0, 4'd6};
    tbl[4] = '{1'b0, 2'd3, 4'd0, 4'd3};
    tbl[5] = '{1'b0, 2'd0, 4'd0, 4'd3};

    // Reset values
    tick(); tick();
    chk("rst_arrRData", arrRData, 4'd0);
    chk("rst_hostRData", hostRData, 4'd0);
    chk("rst_busy", 4'(busy), 4'd0);
    chk("rst_oobErr", 4'(oobErr), 4'd0);
    chk("rst_b_oobErr", 4'(b_oobErr), 4'd0);
    rst = 1'b0; b_rst = 1'b0;

    // Clear: busy exactly DEPTH cycles, a second pulse mid-clear does not extend it
    clearStart = 1'b1;
    tick();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) cnt++;
      clearStart = (i == 1);
      tick();
    end
    clearStart = 1'b0;
    chk("clear_busy_cycles", 4'(cnt), 4'd4);
    for (int a = 0; a < 4; a++) begin
      hostAddr = 2'(a);
      tick();
      chk($sformatf("clear_rd%0d", a), hostRData, 4'd3);
      mdl[a] = 4'd3;
    end

    // Host table while kernel pokes addr 0 without ownership
    arrWEnable = 1'b1; arrAddr = 2'd0; arrWData = 4'hf;
    for (int i = 0; i < 6; i++) begin
      hostWEnable = tbl[i].we; hostAddr = tbl[i].a; hostWData = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_host", i), hostRData, tbl[i].eh);
      chk($sformatf("tbl%0d_arr", i), arrRData, 4'd0);
    end
    mdl[1] = 4'd5; mdl[2] = 4'd6;
    hostWEnable = 1'b0; arrWEnable = 1'b0; arrAddr = 2'd1;

    // Handoff to kernel: one dead cycle
    controlArr = 1'b1;
    tick();
    chk("handoff_busy", 4'(busy), 4'd1);
    tick();
    chk("handoff_done", 4'(busy), 4'd0);
    chk("handoff_no_serve", arrRData, 4'd0);
    tick();
    chk("kern_rd1", arrRData, 4'd5);
    arrAddr = 2'd2;
    tick();
    chk("kern_rd2", arrRData, 4'd6);
    hostWEnable = 1'b1; hostAddr = 2'd1; hostWData = 4'd9; arrAddr = 2'd1;
    tick();
    hostWEnable = 1'b0;
    chk("host_wr_ignored_a", arrRData, 4'd5);
    chk("host_rdata_hold", hostRData, 4'd3);
    tick();
    chk("host_wr_ignored_b", arrRData, 4'd5);

    // Same-cycle kernel write/read
    arrWEnable = 1'b1; arrAddr = 2'd2; arrWData = 4'd3;
    tick();
    chk("kern_wr3", arrRData, FWD ? 4'd3 : 4'd6);
    arrWData = 4'd7;
    tick();
    chk("same_cycle_wr_rd", arrRData, FWD ? 4'd7 : 4'd3);
    arrWEnable = 1'b0;
    tick();
    chk("after_wr7", arrRData, 4'd7);
    mdl[2] = 4'd7;
    exp_h = 4'd3; exp_k = 4'd7; kern = 1'b1;

    // Randomized traffic with periodic ownership switches
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 30; c++) begin
        arrWEnable  = 1'($urandom_range(0, 1)); arrAddr  = 2'($urandom_range(0, 3));
        arrWData    = 4'($urandom);
        hostWEnable = 1'($urandom_range(0, 1)); hostAddr = 2'($urandom_range(0, 3));
        hostWData   = 4'($urandom);
        tick();
        if (kern) exp_k = srv(arrWEnable, arrAddr, arrWData);
        else      exp_h = srv(hostWEnable, hostAddr, hostWData);
        chk("rnd_arr", arrRData, exp_k);
        chk("rnd_host", hostRData, exp_h);
      end
      arrWEnable = 1'b0; hostWEnable = 1'b0; controlArr = ~kern;
      tick();
      if (kern) exp_k = srv(1'b0, arrAddr, 4'd0);
      else      exp_h = srv(1'b0, hostAddr, 4'd0);
      chk("rnd_sw_busy", 4'(busy), 4'd1);
      tick();
      chk("rnd_sw_idle", 4'(busy), 4'd0);
      chk("rnd_sw_arr", arrRData, exp_k);
      chk("rnd_sw_host", hostRData, exp_h);
      kern = ~kern;
    end

    // Back to host, then reset in the second cycle of a clear
    controlArr = 1'b0; hostAddr = 2'd0;
    tick(); tick();
    hostWEnable = 1'b1; hostAddr = 2'd0; hostWData = 4'hb;
    tick();
    hostAddr = 2'd3; hostWData = 4'ha;
    tick();
    hostWEnable = 1'b0; clearStart = 1'b1;
    tick();
    clearStart = 1'b0;
    chk("rclr_busy", 4'(busy), 4'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rclr_busy_low", 4'(busy), 4'd0);
    chk("rclr_hostRData", hostRData, 4'd0);
    rst = 1'b0; hostAddr = 2'd0;
    tick();
    chk("rclr_addr0", hostRData, 4'd3);
    hostAddr = 2'd3;
    tick();
    chk("rclr_addr3", hostRData, 4'ha);
    chk("main_oob_clear", 4'(oobErr), 4'd0);

    // Out-of-range kernel access on the DEPTH=3 instance
    b_controlArr = 1'b1;
    tick(); tick();
    b_arrWEnable = 1'b1; b_arrAddr = 2'd2; b_arrWData = 4'd4;
    tick();
    chk("oob_pre", 4'(b_oobErr), 4'd0);
    b_arrAddr = 2'd3; b_arrWData = 4'd7;
    tick();
    chk("oob_rdata", b_arrRData, 4'd0);
    chk("oob_flag", 4'(b_oobErr), 4'd1);
    b_arrWEnable = 1'b0; b_arrAddr = 2'd2;
    tick();
    chk("oob_addr2_intact", b_arrRData, 4'd4);
    tick(); tick();
    chk("oob_sticky", 4'(b_oobErr), 4'd1);
    b_rst = 1'b1;
    tick();
    chk("oob_rst", 4'(b_oobErr), 4'd0);
    b_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
